// File: rtl/radio_pkg.sv
// Shared definitions for the radio deserialiser: frame geometry, output field
// positions inside WORD, and the framer state encoding.
package radio_pkg;

    localparam int FRAME_W = 8;   // bits per frame
    localparam int IDX_W   = 3;   // bit index width, 0..7
    localparam int CNT_W   = 4;   // good/miss counters, thresholds 1..15
    localparam int FIELD_W = 2;   // width of each I/Q field

    localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

    // LSB position of each field inside WORD
    localparam int R0_I_LSB = 6;
    localparam int R0_Q_LSB = 4;
    localparam int R1_I_LSB = 2;
    localparam int R1_Q_LSB = 0;

    // Framer states
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Extract one 2-bit field from a frame word
    function automatic logic [FIELD_W-1:0] get_field(input logic [FRAME_W-1:0] w,
                                                     input int lsb);
        return w[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/radio_deser_framer.sv
// Frame synchroniser: HUNT/VERIFY/LOCKED state machine, bit index, good and
// miss counters. Produces the bit position of the current sample, a strobe for
// frames that must be output, the lock flag and the per-frame error pulse.
module radio_deser_framer
    import radio_pkg::*;
#(
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 3
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             SYNC_IN,
    output logic [IDX_W-1:0] bit_idx,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_COUNT);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             frame_bad_q, frame_bad_d;
    logic             sync_err_q, err_first;
    logic             viol, bad_before;

    // Next-state decode: lock acquisition, realignment and loss-of-lock rules
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d     = state_q;
        good_d      = good_q;
        miss_d      = miss_q;
        frame_bad_d = 1'b0;
        err_first   = 1'b0;
        frame_done  = 1'b0;
        viol        = 1'b0;
        bad_before  = 1'b0;
        // Outside LOCKED a SYNC pulse defines bit 0; in LOCKED the index free-runs
        bit_idx     = (state_q != ST_LOCKED && SYNC_IN) ? '0 : idx_q;

        case (state_q)
            ST_HUNT: begin
                if (SYNC_IN) begin
                    good_d  = CNT_W'(1);
                    miss_d  = '0;
                    state_d = (LOCK_N == CNT_W'(1)) ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (idx_q == '0) begin
                    if (SYNC_IN) begin
                        good_d = good_q + 1'b1;
                        if (good_d >= LOCK_N) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end else if (SYNC_IN) begin
                    good_d = CNT_W'(1);   // realign: this bit is the new bit 0
                end
            end
            ST_LOCKED: begin
                viol        = (idx_q == '0) ? !SYNC_IN : SYNC_IN;
                bad_before  = (idx_q == '0) ? 1'b0 : frame_bad_q;
                frame_bad_d = bad_before | viol;
                // A frame is counted bad once, at its first offending cycle
                if (viol && !bad_before) begin
                    err_first = 1'b1;
                    miss_d    = miss_q + 1'b1;
                    if (miss_d >= LOSS_N) state_d = ST_HUNT;
                end
                // Complete frame still output unless this edge dropped lock
                if (idx_q == IDX_LAST && state_d == ST_LOCKED) begin
                    frame_done = 1'b1;
                    if (!frame_bad_d) miss_d = '0;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // State, index and counter registers
    always_ff @(posedge SYS_CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            state_q     <= ST_HUNT;
            idx_q       <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            frame_bad_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= bit_idx + 1'b1;
            good_q      <= good_d;
            miss_q      <= miss_d;
            frame_bad_q <= frame_bad_d;
            sync_err_q  <= err_first;
        end
    end

    assign locked   = (state_q == ST_LOCKED);
    assign sync_err = sync_err_q;

endmodule

// File: rtl/radio_deser.sv
// Serial radio deserialiser top: LSB-first 8-bit frames framed by SYNC_IN,
// output as WORD plus four 2-bit I/Q fields once the framer is locked.
// Optional statistics counters are enabled with `define RADIO_DESER_STATS_EN.
module radio_deser
    import radio_pkg::*;
#(
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 3
) (
    input  logic               SYS_CLK,
    input  logic               RST,
    input  logic               DATA_IN,
    input  logic               SYNC_IN,
    output logic [FRAME_W-1:0] WORD,
    output logic [1:0]         R0_I,
    output logic [1:0]         R0_Q,
    output logic [1:0]         R1_I,
    output logic [1:0]         R1_Q,
    output logic               WORD_VALID,
    output logic               LOCKED,
    output logic               SYNC_ERR
`ifdef RADIO_DESER_STATS_EN
    ,
    output logic [31:0]        WORD_COUNT,
    output logic [15:0]        ERR_COUNT
`endif
);

    logic [IDX_W-1:0]   bit_idx;
    logic               frame_done;
    logic [FRAME_W-1:0] sh_q, frame_word, word_q;
    logic               word_valid_q;

    radio_deser_framer #(
        .LOCK_COUNT(LOCK_COUNT),
        .LOSS_COUNT(LOSS_COUNT)
    ) u_framer (
        .SYS_CLK   (SYS_CLK),
        .RST       (RST),
        .SYNC_IN   (SYNC_IN),
        .bit_idx   (bit_idx),
        .frame_done(frame_done),
        .locked    (LOCKED),
        .sync_err  (SYNC_ERR)
    );

    // Completed frame as it will look with the current bit written in
    always_comb begin
        frame_word          = sh_q;
        frame_word[bit_idx] = DATA_IN;
    end

    // Shift register and output word registers
    always_ff @(posedge SYS_CLK) begin
        // NOTE: the shift register is reset too, so a partial frame never survives reset.
        if (RST) begin
            sh_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            sh_q[bit_idx] <= DATA_IN;
            word_valid_q  <= frame_done;
            if (frame_done) word_q <= frame_word;
        end
    end

    assign WORD       = word_q;
    assign WORD_VALID = word_valid_q;
    assign R0_I       = get_field(word_q, R0_I_LSB);
    assign R0_Q       = get_field(word_q, R0_Q_LSB);
    assign R1_I       = get_field(word_q, R1_I_LSB);
    assign R1_Q       = get_field(word_q, R1_Q_LSB);

`ifdef RADIO_DESER_STATS_EN
    logic [31:0] word_cnt_q;
    logic [15:0] err_cnt_q;

    // Pulse counters: words wrap, errors saturate
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (word_valid_q) word_cnt_q <= word_cnt_q + 32'd1;
            if (SYNC_ERR && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign WORD_COUNT = word_cnt_q;
    assign ERR_COUNT  = err_cnt_q;
`endif

endmodule

// File: tb/tb_radio_deser.sv
// Self-checking bench for radio_deser: a per-bit behavioural model of the
// framing rules, a compare process sampling 2 time units after each rising
// edge, directed sequences with literal expectations, then random traffic.
module tb_radio_deser;

    localparam int LOCK_COUNT = 2;
    localparam int LOSS_COUNT = 3;

    logic       SYS_CLK = 1'b0;
    logic       RST     = 1'b1;
    logic       DATA_IN = 1'b0;
    logic       SYNC_IN = 1'b0;
    logic [7:0] WORD;
    logic [1:0] R0_I, R0_Q, R1_I, R1_Q;
    logic       WORD_VALID, LOCKED, SYNC_ERR;
`ifdef RADIO_DESER_STATS_EN
    logic [31:0] WORD_COUNT;
    logic [15:0] ERR_COUNT;
`endif

    radio_deser #(
        .LOCK_COUNT(LOCK_COUNT),
        .LOSS_COUNT(LOSS_COUNT)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .RST       (RST),
        .DATA_IN   (DATA_IN),
        .SYNC_IN   (SYNC_IN),
        .WORD      (WORD),
        .R0_I      (R0_I),
        .R0_Q      (R0_Q),
        .R1_I      (R1_I),
        .R1_Q      (R1_Q),
        .WORD_VALID(WORD_VALID),
        .LOCKED    (LOCKED),
        .SYNC_ERR  (SYNC_ERR)
`ifdef RADIO_DESER_STATS_EN
        ,
        .WORD_COUNT(WORD_COUNT),
        .ERR_COUNT (ERR_COUNT)
`endif
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int vectors     = 0;
    int miscompares = 0;
    int n_valid     = 0;   // WORD_VALID pulses observed
    int n_err       = 0;   // SYNC_ERR pulses observed

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_HUNT, M_VERIFY, M_LOCK} mmode_t;
    mmode_t     m_mode = M_HUNT;
    int         m_next = 0;      // expected position of the next bit
    int         m_good = 0;
    int         m_miss = 0;
    bit         m_bad  = 0;      // current locked frame already counted bad
    logic [7:0] m_bits = '0;     // bits of the frame being assembled
    logic [7:0] e_word = '0;
    bit         e_valid = 0, e_err = 0;

    // Advance the model by one bit; results describe outputs after that edge
    task automatic model_step(input logic rst, input logic sync, input logic data);
        int pos;
        bit viol;
        e_valid = 0;
        e_err   = 0;
        if (rst) begin
            m_mode = M_HUNT; m_next = 0; m_good = 0; m_miss = 0; m_bad = 0;
            m_bits = '0; e_word = '0;
        end else begin
            pos = (m_mode != M_LOCK && sync) ? 0 : m_next;
            m_bits[pos] = data;
            case (m_mode)
                M_HUNT: if (sync) begin
                    m_good = 1; m_miss = 0; m_bad = 0;
                    m_mode = (LOCK_COUNT == 1) ? M_LOCK : M_VERIFY;
                end
                M_VERIFY: begin
                    if (sync && m_next != 0) m_good = 1;
                    else if (sync) begin
                        m_good++;
                        if (m_good >= LOCK_COUNT) begin
                            m_mode = M_LOCK; m_miss = 0; m_bad = 0;
                        end
                    end else if (pos == 0) m_mode = M_HUNT;
                end
                default: begin
                    viol = (pos == 0) ? !sync : sync;
                    if (pos == 0) m_bad = 0;
                    if (viol && !m_bad) begin
                        m_bad = 1; e_err = 1; m_miss++;
                        if (m_miss >= LOSS_COUNT) m_mode = M_HUNT;
                    end
                    if (pos == 7 && m_mode == M_LOCK) begin
                        e_valid = 1; e_word = m_bits;
                        if (!m_bad) m_miss = 0;
                    end
                end
            endcase
            m_next = (pos + 1) % 8;
        end
    endtask

    // Compare process: every cycle, after the edge has settled
    always @(posedge SYS_CLK) begin
        #2;
        check("word",       32'(WORD),       32'(e_word));
        check("r0_i",       32'(R0_I),       32'(e_word[7:6]));
        check("r0_q",       32'(R0_Q),       32'(e_word[5:4]));
        check("r1_i",       32'(R1_I),       32'(e_word[3:2]));
        check("r1_q",       32'(R1_Q),       32'(e_word[1:0]));
        check("word_valid", 32'(WORD_VALID), 32'(e_valid));
        check("locked",     32'(LOCKED),     32'(m_mode == M_LOCK));
        check("sync_err",   32'(SYNC_ERR),   32'(e_err));
        if (WORD_VALID) n_valid++;
        if (SYNC_ERR)   n_err++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic rst, input logic sync, input logic data);
        @(negedge SYS_CLK);
        RST = rst; SYNC_IN = sync; DATA_IN = data;
        model_step(rst, sync, data);
        @(posedge SYS_CLK);
        #3;
    endtask

    // One frame, LSB first; SYNC on bit 0 if sync0, plus a spurious SYNC at spur
    task automatic send_frame(input logic [7:0] b, input bit sync0, input int spur,
                              output bit locked_after0);
        locked_after0 = 0;
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b0, (i == 0 && sync0) || (i == spur), b[i]);
            if (i == 0) locked_after0 = LOCKED;
        end
    endtask

    initial begin
        bit l0;
        int v0, e0;
        int gpos;
        logic rs, sy;

        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b1);
        check("reset_word",   32'(WORD), 32'h0);
        check("reset_valid",  32'(WORD_VALID), 32'h0);
        check("reset_locked", 32'(LOCKED), 32'h0);
        check("reset_err",    32'(SYNC_ERR), 32'h0);

        // Lock acquisition: 0xA5 only verifies, 0x3C and 0x0F are output
        v0 = n_valid;
        send_frame(8'hA5, 1, -1, l0);
        check("a5_not_locked", 32'(LOCKED), 32'h0);
        check("a5_not_output", 32'(n_valid - v0), 32'h0);
        send_frame(8'h3C, 1, -1, l0);
        check("locked_after_edge8", 32'(l0), 32'h1);
        check("word_3c",  32'(WORD), 32'h3C);
        check("valid_3c", 32'(WORD_VALID), 32'h1);
        check("r0_i_3c",  32'(R0_I), 32'h0);
        check("r0_q_3c",  32'(R0_Q), 32'h3);
        check("r1_i_3c",  32'(R1_I), 32'h3);
        check("r1_q_3c",  32'(R1_Q), 32'h0);
        send_frame(8'h0F, 1, -1, l0);
        check("word_0f",  32'(WORD), 32'h0F);
        check("valid_0f", 32'(WORD_VALID), 32'h1);

        // Two missing SYNCs then restored: stays locked, miss count clears
        v0 = n_valid; e0 = n_err;
        send_frame(8'h11, 0, -1, l0);
        send_frame(8'h22, 0, -1, l0);
        check("miss2_errs",   32'(n_err - e0), 32'h2);
        check("miss2_words",  32'(n_valid - v0), 32'h2);
        check("miss2_locked", 32'(LOCKED), 32'h1);
        check("miss2_word",   32'(WORD), 32'h22);
        send_frame(8'h33, 1, -1, l0);
        send_frame(8'h44, 0, -1, l0);
        send_frame(8'h55, 0, -1, l0);
        check("miss_cleared_locked", 32'(LOCKED), 32'h1);
        send_frame(8'h66, 1, -1, l0);
`ifdef RADIO_DESER_STATS_EN
        check("stats_words", WORD_COUNT, 32'(n_valid - int'(WORD_VALID)));
        check("stats_errs",  32'(ERR_COUNT), 32'(n_err - int'(SYNC_ERR)));
`endif

        // Three missing SYNCs: lock drops at the third bit-0 edge
        v0 = n_valid;
        send_frame(8'h71, 0, -1, l0);
        check("loss_f1_locked", 32'(l0), 32'h1);
        send_frame(8'h72, 0, -1, l0);
        check("loss_f2_locked", 32'(l0), 32'h1);
        send_frame(8'h73, 0, -1, l0);
        check("loss_f3_unlocked", 32'(l0), 32'h0);
        check("loss_words", 32'(n_valid - v0), 32'h2);
        send_frame(8'h74, 1, -1, l0);
        check("relock_pending_words", 32'(n_valid - v0), 32'h2);
        send_frame(8'h75, 1, -1, l0);
        check("relock_locked", 32'(l0), 32'h1);
        check("relock_word",   32'(WORD), 32'h75);

        // Realignment in VERIFY on a spurious SYNC at index 3
        drive_bit(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 10; e++) drive_bit(1'b0, e == 0 || e == 3, e[0]);
        check("realign_not_locked", 32'(LOCKED), 32'h0);
        send_frame(8'hC9, 1, -1, l0);
        check("realign_locked", 32'(l0), 32'h1);
        check("realign_word",   32'(WORD), 32'hC9);

        // Reset at index 4 while locked
        for (int i = 0; i < 4; i++) drive_bit(1'b0, i == 0, 1'b1);
        drive_bit(1'b1, 1'b0, 1'b1);
        check("rst_word",   32'(WORD), 32'h0);
        check("rst_valid",  32'(WORD_VALID), 32'h0);
        check("rst_locked", 32'(LOCKED), 32'h0);
        check("rst_err",    32'(SYNC_ERR), 32'h0);
        send_frame(8'hE7, 1, -1, l0);
        check("rst_relock_needs_two", 32'(l0), 32'h0);
        send_frame(8'h18, 1, -1, l0);
        check("rst_relock", 32'(l0), 32'h1);
        check("rst_relock_word", 32'(WORD), 32'h18);

`ifdef RADIO_DESER_STATS_EN
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        send_frame(8'h01, 0, -1, l0);
        send_frame(8'h02, 0, -1, l0);
        drive_bit(1'b0, 1'b1, 1'b0);
        check("stats_err_saturate", 32'(ERR_COUNT), 32'hFFFF);
`endif

        // Random traffic: mostly well-spaced SYNCs with drops, spurs, slips, resets
        gpos = 0;
        for (int n = 0; n < 4000; n++) begin
            rs = ($urandom_range(0, 999) < 3);
            if (gpos == 0) sy = ($urandom_range(0, 99) < 85);
            else           sy = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 199) == 0) gpos = $urandom_range(0, 7);
            drive_bit(rs, sy, 1'($urandom_range(0, 1)));
            gpos = (gpos + 1) % 8;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
